// File: rtl/exu_dp_slave.sv
// Execute-stage datapath responder: GPR file, single-cycle ALU and a 1-bit/cycle shifter.
// One operation per valid/ready handshake; done pulses in the cycle the writeback commits.
module exu_dp_slave #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned GPR_NUM = 32,
  parameter int unsigned OPC_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_vld,
  output logic             op_rdy,
  input  logic [OPC_W-1:0] alu_opcode,
  input  logic [XLEN-1:0]  alu_src1,
  input  logic [XLEN-1:0]  alu_src2,
  input  logic [4:0]       gpr_raddr1,
  input  logic [4:0]       gpr_raddr2,
  output logic [XLEN-1:0]  gpr_rdata1,
  output logic [XLEN-1:0]  gpr_rdata2,
  input  logic [4:0]       gpr_waddr,
  input  logic             gpr_wen,
  input  logic             wb_src,
  input  logic [XLEN-1:0]  gpr_wdata,
  output logic [XLEN-1:0]  alu_dst,
  output logic             done
);

  localparam logic [OPC_W-1:0] AluAdd   = OPC_W'(0);
  localparam logic [OPC_W-1:0] AluLessS = OPC_W'(1);
  localparam logic [OPC_W-1:0] AluLessU = OPC_W'(2);
  localparam logic [OPC_W-1:0] AluXor   = OPC_W'(3);
  localparam logic [OPC_W-1:0] AluOr    = OPC_W'(4);
  localparam logic [OPC_W-1:0] AluAnd   = OPC_W'(5);
  localparam logic [OPC_W-1:0] AluSl    = OPC_W'(6);
  localparam logic [OPC_W-1:0] AluSrl   = OPC_W'(7);
  localparam logic [OPC_W-1:0] AluSra   = OPC_W'(8);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opc_q;
  logic [4:0]        waddr_q;
  logic              wen_q;
  logic              wb_src_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   res_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   gpr_q [GPR_NUM];

  logic              accept;
  logic              is_shift;
  logic              shift_start;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   sh_next;
  logic              wb_commit;
  logic [XLEN-1:0]   wb_data;

  assign accept      = op_vld && op_rdy;
  assign is_shift    = (alu_opcode == AluSl) || (alu_opcode == AluSrl) || (alu_opcode == AluSra);
  assign shift_start = is_shift && (alu_src2[4:0] != 5'd0);

  // Shift opcodes pass src1 through; the shifter does the work over later cycles.
  always_comb begin
    alu_res = '0;
    case (alu_opcode)
      AluAdd:                alu_res = alu_src1 + alu_src2;
      AluLessS:              alu_res = XLEN'($signed(alu_src1) < $signed(alu_src2));
      AluLessU:              alu_res = XLEN'(alu_src1 < alu_src2);
      AluXor:                alu_res = alu_src1 ^ alu_src2;
      AluOr:                 alu_res = alu_src1 | alu_src2;
      AluAnd:                alu_res = alu_src1 & alu_src2;
      AluSl, AluSrl, AluSra: alu_res = alu_src1;
      default:               alu_res = '0;
    endcase
  end

  always_comb begin
    sh_next = res_q;
    case (opc_q)
      AluSl:   sh_next = {res_q[XLEN-2:0], 1'b0};
      AluSrl:  sh_next = {1'b0, res_q[XLEN-1:1]};
      AluSra:  sh_next = {res_q[XLEN-1], res_q[XLEN-1:1]};
      default: sh_next = res_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = shift_start ? StShift : StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q == 5'd1) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    op_rdy = (state_q != StShift);
    done   = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q    <= '0;
      waddr_q  <= '0;
      wen_q    <= 1'b0;
      wb_src_q <= 1'b0;
      wdata_q  <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      opc_q    <= alu_opcode;
      waddr_q  <= gpr_waddr;
      wen_q    <= gpr_wen;
      wb_src_q <= wb_src;
      wdata_q  <= gpr_wdata;
      res_q    <= shift_start ? alu_src1 : alu_res;
      cnt_q    <= shift_start ? alu_src2[4:0] : 5'd0;
    end else if (state_q == StShift) begin
      res_q <= sh_next;
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign alu_dst   = res_q;
  assign wb_commit = (state_q == StDone) && wen_q && (waddr_q != 5'd0);
  assign wb_data   = wb_src_q ? wdata_q : res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < GPR_NUM; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wb_commit) begin
      gpr_q[waddr_q] <= wb_data;
    end
  end

  // Reads bypass the writeback that commits at the end of this DONE cycle.
  always_comb begin
    if (gpr_raddr1 == 5'd0) begin
      gpr_rdata1 = '0;
    end else if (wb_commit && (gpr_raddr1 == waddr_q)) begin
      gpr_rdata1 = wb_data;
    end else begin
      gpr_rdata1 = gpr_q[gpr_raddr1];
    end
    if (gpr_raddr2 == 5'd0) begin
      gpr_rdata2 = '0;
    end else if (wb_commit && (gpr_raddr2 == waddr_q)) begin
      gpr_rdata2 = wb_data;
    end else begin
      gpr_rdata2 = gpr_q[gpr_raddr2];
    end
  end

endmodule

// File: tb/tb_exu_dp_slave.sv
// Directed plus randomized bench for exu_dp_slave, checked against a behavioural model
// of the GPR file and operation results.
module tb_exu_dp_slave;

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpLessS = 4'd1;
  localparam logic [3:0] OpLessU = 4'd2;
  localparam logic [3:0] OpXor   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpAnd   = 4'd5;
  localparam logic [3:0] OpSl    = 4'd6;
  localparam logic [3:0] OpSrl   = 4'd7;
  localparam logic [3:0] OpSra   = 4'd8;

  logic        clk;
  logic        rst_n;
  logic        op_vld;
  logic        op_rdy;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  gpr_raddr1;
  logic [4:0]  gpr_raddr2;
  logic [31:0] gpr_rdata1;
  logic [31:0] gpr_rdata2;
  logic [4:0]  gpr_waddr;
  logic        gpr_wen;
  logic        wb_src;
  logic [31:0] gpr_wdata;
  logic [31:0] alu_dst;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_gpr [32];

  exu_dp_slave #(
    .XLEN   (32),
    .GPR_NUM(32),
    .OPC_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_vld    (op_vld),
    .op_rdy    (op_rdy),
    .alu_opcode(alu_opcode),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .gpr_raddr1(gpr_raddr1),
    .gpr_raddr2(gpr_raddr2),
    .gpr_rdata1(gpr_rdata1),
    .gpr_rdata2(gpr_rdata2),
    .gpr_waddr (gpr_waddr),
    .gpr_wen   (gpr_wen),
    .wb_src    (wb_src),
    .gpr_wdata (gpr_wdata),
    .alu_dst   (alu_dst),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] opc, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (opc)
      OpAdd:   return a + b;
      OpLessS: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpLessU: return (a < b) ? 32'd1 : 32'd0;
      OpXor:   return a ^ b;
      OpOr:    return a | b;
      OpAnd:   return a & b;
      OpSl:    return a << b[4:0];
      OpSrl:   return a >> b[4:0];
      OpSra:   return sa >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [3:0] opc, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] wa, input logic we,
                       input logic ws, input logic [31:0] wd);
    logic [31:0] exp_res;
    int lat_exp;
    int cyc;
    bit rdy_bad;
    exp_res = ref_alu(opc, s1, s2);
    lat_exp = ((opc == OpSl || opc == OpSrl || opc == OpSra) && s2[4:0] != 5'd0)
              ? int'(s2[4:0]) + 1 : 1;
    alu_opcode = opc;
    alu_src1   = s1;
    alu_src2   = s2;
    gpr_waddr  = wa;
    gpr_wen    = we;
    wb_src     = ws;
    gpr_wdata  = wd;
    op_vld     = 1'b1;
    tick();
    cyc     = 1;
    rdy_bad = 1'b0;
    // op_vld stays high while shifting; it must not cause a second accept
    while (!done && cyc < 80) begin
      if (op_rdy) rdy_bad = 1'b1;
      tick();
      cyc++;
    end
    op_vld = 1'b0;
    check({tag, " latency"}, cyc, lat_exp);
    check({tag, " op_rdy low while busy"}, 32'(rdy_bad), 32'd0);
    check({tag, " alu_dst"}, alu_dst, exp_res);
    if (we && wa != 5'd0) model_gpr[wa] = ws ? wd : exp_res;
    gpr_raddr2 = wa;
    #1;
    check({tag, " bypass read"}, gpr_rdata2, model_gpr[wa]);
    tick();
    check({tag, " single done pulse"}, 32'(done), 32'd0);
    gpr_raddr1 = wa;
    #1;
    check({tag, " readback"}, gpr_rdata1, model_gpr[wa]);
  endtask

  initial begin
    int npulse;
    logic [3:0] ropc;
    rst_n      = 1'b0;
    op_vld     = 1'b0;
    alu_opcode = '0;
    alu_src1   = '0;
    alu_src2   = '0;
    gpr_raddr1 = '0;
    gpr_raddr2 = '0;
    gpr_waddr  = '0;
    gpr_wen    = 1'b0;
    wb_src     = 1'b0;
    gpr_wdata  = '0;
    for (int i = 0; i < 32; i++) model_gpr[i] = '0;

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("reset op_rdy", 32'(op_rdy), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset alu_dst", alu_dst, 32'd0);
    for (int i = 0; i < 32; i++) begin
      gpr_raddr1 = 5'(i);
      gpr_raddr2 = 5'(31 - i);
      #1;
      check("reset rdata1", gpr_rdata1, 32'd0);
      check("reset rdata2", gpr_rdata2, 32'd0);
    end

    // Directed operations
    do_op("add wrap", OpAdd, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 1'b0, 32'h0);
    check("add x5", model_gpr[5], 32'd1);
    do_op("less_s", OpLessS, 32'h8000_0000, 32'd1, 5'd0, 1'b1, 1'b0, 32'h0);
    do_op("less_u", OpLessU, 32'h8000_0000, 32'd1, 5'd0, 1'b1, 1'b0, 32'h0);
    do_op("sra4", OpSra, 32'h8000_0010, 32'd4, 5'd7, 1'b1, 1'b0, 32'h0);
    do_op("sl0", OpSl, 32'h1234_5678, 32'h20, 5'd8, 1'b1, 1'b0, 32'h0);
    do_op("srl31", OpSrl, 32'h8000_0000, 32'd31, 5'd10, 1'b1, 1'b0, 32'h0);
    do_op("ext wb", OpAnd, 32'hFFFF, 32'hF0F0, 5'd11, 1'b1, 1'b1, 32'hCAFE_BABE);
    do_op("unknown opc", 4'hF, 32'h55, 32'hAA, 5'd12, 1'b1, 1'b0, 32'h0);
    do_op("no wen", OpOr, 32'h1, 32'h2, 5'd5, 1'b0, 1'b0, 32'h0);

    // Back-to-back with bypass in the DONE cycle
    alu_opcode = OpAdd;
    alu_src1   = 32'd3;
    alu_src2   = 32'd4;
    gpr_waddr  = 5'd3;
    gpr_wen    = 1'b1;
    wb_src     = 1'b0;
    op_vld     = 1'b1;
    tick();
    check("b2b done1", 32'(done), 32'd1);
    gpr_raddr1 = 5'd3;
    #1;
    check("b2b bypass x3", gpr_rdata1, 32'd7);
    alu_opcode = OpXor;
    alu_src1   = gpr_rdata1;
    alu_src2   = 32'd1;
    gpr_waddr  = 5'd4;
    tick();
    op_vld = 1'b0;
    model_gpr[3] = 32'd7;
    model_gpr[4] = 32'd6;
    check("b2b done2", 32'(done), 32'd1);
    check("b2b xor", alu_dst, 32'd6);
    tick();
    check("b2b idle", 32'(done), 32'd0);
    gpr_raddr1 = 5'd3;
    gpr_raddr2 = 5'd4;
    #1;
    check("b2b x3", gpr_rdata1, model_gpr[3]);
    check("b2b x4", gpr_rdata2, model_gpr[4]);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      ropc = 4'($urandom_range(0, 9));
      if (ropc == 4'd9) ropc = 4'hF;
      do_op("rand", ropc, $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), $urandom);
    end

    // Reset in the middle of a long shift
    alu_opcode = OpSl;
    alu_src1   = 32'd1;
    alu_src2   = 32'd20;
    gpr_waddr  = 5'd9;
    gpr_wen    = 1'b1;
    wb_src     = 1'b0;
    op_vld     = 1'b1;
    tick();
    op_vld = 1'b0;
    repeat (5) tick();
    check("mid-shift busy", 32'(op_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset op_rdy", 32'(op_rdy), 32'd1);
    check("async reset done", 32'(done), 32'd0);
    check("async reset alu_dst", alu_dst, 32'd0);
    for (int i = 0; i < 32; i++) model_gpr[i] = '0;
    tick();
    rst_n  = 1'b1;
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) npulse++;
    end
    check("no done after reset", 32'(npulse), 32'd0);
    gpr_raddr1 = 5'd9;
    gpr_raddr2 = 5'd5;
    #1;
    check("x9 after reset", gpr_rdata1, model_gpr[9]);
    check("x5 after reset", gpr_rdata2, model_gpr[5]);
    do_op("post-reset add", OpAdd, 32'd40, 32'd2, 5'd9, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exu_dp_slave.md
Name: exu_dp_slave

Overview:
- Datapath responder for the execute stage: serves the control signals that the per-instruction handlers (ALU-immediate, ALU-register, load, LUI) drive.
- Contains the 32x32 GPR file, a single-cycle ALU for add/logic/compare, and an iterative 1-bit-per-cycle shifter.
- Accepts one operation per valid/ready handshake, computes the result, and commits the GPR writeback.
- Signals completion to the execute-stage sequencer with a one-cycle done pulse.

Parameters:
- XLEN, 32, data width.
- GPR_NUM, 32, number of GPRs; register 0 is hardwired to zero.
- OPC_W, `ALU_OPC_SIZE, ALU opcode width; encodings are ALU_OPCODE_* from exu/dp.svh.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- op_vld  in  1  operation request valid.
- op_rdy  out  1  block can accept an operation this cycle.
- alu_opcode  in  OPC_W  ALU operation.
- alu_src1  in  XLEN  ALU operand 1.
- alu_src2  in  XLEN  ALU operand 2; for shifts, bits [4:0] are the shift amount.
- gpr_raddr1  in  5  read port 1 address.
- gpr_raddr2  in  5  read port 2 address.
- gpr_rdata1  out  XLEN  read port 1 data, combinational.
- gpr_rdata2  out  XLEN  read port 2 data, combinational.
- gpr_waddr  in  5  writeback register, sampled at accept.
- gpr_wen  in  1  writeback enable, sampled at accept.
- wb_src  in  1  writeback source, sampled at accept: 0 = ALU result, 1 = gpr_wdata.
- gpr_wdata  in  XLEN  external writeback data, sampled at accept.
- alu_dst  out  XLEN  registered ALU result.
- done  out  1  one-cycle pulse: operation complete; writeback commits on this cycle's rising edge.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all GPRs = 0; alu_dst = 0; done = 0; op_rdy = 1; shift counter = 0.
  - An in-flight operation is discarded with no writeback.
- States: IDLE, SHIFT, DONE.
- op_rdy = 1 in IDLE and DONE, 0 in SHIFT. Accept occurs when op_vld && op_rdy at a rising edge. In SHIFT, op_vld is ignored and the requester holds its inputs.
- Accept latches opcode, gpr_waddr, gpr_wen, wb_src and gpr_wdata. Then:
  - Shift opcode (SL/SRL/SRA) with alu_src2[4:0] != 0: res <= alu_src1; cnt <= alu_src2[4:0]; go to SHIFT.
  - Otherwise: res <= ALU(src1, src2); go to DONE.
  - Shift with amount 0: res = src1, go to DONE.
- ALU (single cycle):
  - ADD: modulo 2^32.
  - LESS_S: signed compare, result 1 or 0, zero-extended.
  - LESS_U: unsigned compare, result 1 or 0, zero-extended.
  - XOR, OR, AND: bitwise.
  - Unknown opcode: result 0.
- SHIFT, per cycle:
  - SL shifts left by 1 with 0 fill; SRL shifts right by 1 with 0 fill; SRA shifts right by 1 replicating bit 31.
  - cnt <= cnt-1; go to DONE when cnt == 1.
- DONE:
  - done = 1.
  - If the latched wen is set and waddr != 0, GPR[waddr] is written at the edge ending DONE. Data is alu_dst if wb_src = 0, else the latched gpr_wdata.
  - From DONE: accept → as from IDLE (back-to-back, no bubble); no accept → IDLE.
- Latency from the accept edge to the done cycle:
  - 1 cycle for non-shifts and zero-amount shifts.
  - shamt+1 cycles for shifts.
  - Sustained throughput for non-shifts is 1 op per cycle.
- alu_dst holds its value until the next operation updates res.
- Reads:
  - Address 0 returns 0.
  - Read-during-write bypass: in a DONE cycle with a pending write to address A != 0, a read of A returns the writeback data.
- Writes to register 0 are dropped; done still pulses.

Test Plan:
- Reset, then read all 32 addresses on both ports → all 0; op_rdy = 1; done = 0.
- ADD: src1 = 0xFFFF_FFFF, src2 = 2, waddr = 5, wen = 1 → done 1 cycle after accept, alu_dst = 0x0000_0001; next cycle gpr_rdata1 (raddr1 = 5) = 1.
- LESS_S vs LESS_U: src1 = 0x8000_0000, src2 = 1 → LESS_S gives 1, LESS_U gives 0; wen = 1 with waddr = 0 → register 0 still reads 0.
- SRA: src1 = 0x8000_0010, shamt = 4 → op_rdy low for 4 cycles, done at accept+5, alu_dst = 0xF800_0001. SL with shamt = 0 → done at accept+1, result = src1. op_vld held during SHIFT is not accepted twice.
- Back-to-back: ADD writing x3 = 7, then XOR accepted in the DONE cycle with src1 taken from gpr_rdata1 (raddr1 = 3), src2 = 1 → bypass delivers 7, result 6; two done pulses on consecutive cycles.
- rst_n asserted mid-SHIFT (SL, shamt = 20, wen = 1, waddr = 9) → no done; x9 reads 0; state IDLE; op_rdy = 1 immediately.
